// File: rtl/mux_scan_sequencer_if.sv
// Channel-address / sample handshake bundle between the scan sequencer (master)
// and the mux decoder + ADC capture side (slave).
interface mux_scan_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] addr;
  logic              sample_req;
  logic              sample_ack;

  modport master (
    output addr,
    output sample_req,
    input  sample_ack
  );

  modport slave (
    input  addr,
    input  sample_req,
    output sample_ack
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the mux decoder address across a programmed channel range, settling and
// handshaking one ADC sample per channel. Optional channel skipping: CHAN_SKIP_EN.
module mux_scan_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int SETTLE_CYC  = 1000,
  parameter int ACK_TIMEOUT = 65535,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [ADDR_W-1:0]      first_ch,
  input  logic [ADDR_W-1:0]      last_ch,
`ifdef CHAN_SKIP_EN
  input  logic [(1<<ADDR_W)-1:0] skip_mask,
`endif
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   timeout_err,
  mux_scan_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    SETTLE = 2'd2,
    REQ    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [ADDR_W-1:0] first_r, first_nxt_s;
  logic [ADDR_W-1:0] last_r, last_nxt_s;
  logic              cont_r, cont_nxt_s;
  logic [CNT_W-1:0]  settle_r, settle_nxt_s;
  logic [CNT_W-1:0]  tmo_r, tmo_nxt_s;
  logic              req_r, req_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic              done_r, done_nxt_s;
  logic              terr_r, terr_nxt_s;

  state_t            adv_state_s;
  logic [ADDR_W-1:0] adv_addr_s;
  logic              adv_done_s;
  logic              skip_s;

`ifdef CHAN_SKIP_EN
  assign skip_s = skip_mask[addr_r];
`else
  assign skip_s = 1'b0;
`endif

  // Where the sweep goes after the current channel is finished (sampled or skipped).
  always_comb begin
    adv_state_s = SEEK;
    adv_addr_s  = addr_r + ADDR_ONE;
    adv_done_s  = 1'b0;
    if (addr_r == last_r) begin
      adv_done_s = 1'b1;
      if (cont_r) begin
        adv_addr_s  = first_r;
        adv_state_s = SEEK;
      end else begin
        adv_addr_s  = addr_r;
        adv_state_s = IDLE;
      end
    end else begin
      adv_done_s = 1'b0;
    end
  end

  // Next-state and next-output logic; stop overrides everything, including start.
  always_comb begin
    state_nxt_s  = state_r;
    addr_nxt_s   = addr_r;
    first_nxt_s  = first_r;
    last_nxt_s   = last_r;
    cont_nxt_s   = cont_r;
    settle_nxt_s = settle_r;
    tmo_nxt_s    = tmo_r;
    req_nxt_s    = req_r;
    done_nxt_s   = 1'b0;
    terr_nxt_s   = terr_r;
    if (stop) begin
      state_nxt_s = IDLE;
      req_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            first_nxt_s = first_ch;
            last_nxt_s  = last_ch;
            cont_nxt_s  = continuous;
            addr_nxt_s  = first_ch;
            terr_nxt_s  = 1'b0;
            state_nxt_s = SEEK;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SEEK: begin
          if (skip_s) begin
            addr_nxt_s  = adv_addr_s;
            done_nxt_s  = adv_done_s;
            state_nxt_s = adv_state_s;
          end else begin
            settle_nxt_s = SETTLE_LOAD;
            state_nxt_s  = SETTLE;
          end
        end
        SETTLE: begin
          if (settle_r == CNT_ZERO) begin
            req_nxt_s   = 1'b1;
            tmo_nxt_s   = CNT_ZERO;
            state_nxt_s = REQ;
          end else begin
            settle_nxt_s = settle_r - CNT_ONE;
          end
        end
        REQ: begin
          // An ack arriving on the timeout cycle itself still counts as in time.
          if (bus.sample_ack) begin
            req_nxt_s   = 1'b0;
            addr_nxt_s  = adv_addr_s;
            done_nxt_s  = adv_done_s;
            state_nxt_s = adv_state_s;
          end else if (tmo_r == TMO_LAST) begin
            req_nxt_s   = 1'b0;
            terr_nxt_s  = 1'b1;
            tmo_nxt_s   = tmo_r + CNT_ONE;
            state_nxt_s = IDLE;
          end else begin
            tmo_nxt_s = tmo_r + CNT_ONE;
          end
        end
        default: begin
          req_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end
      endcase
    end
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State, configuration, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      addr_r   <= {ADDR_W{1'b0}};
      first_r  <= {ADDR_W{1'b0}};
      last_r   <= {ADDR_W{1'b0}};
      cont_r   <= 1'b0;
      settle_r <= CNT_ZERO;
      tmo_r    <= CNT_ZERO;
      req_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      terr_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      addr_r   <= addr_nxt_s;
      first_r  <= first_nxt_s;
      last_r   <= last_nxt_s;
      cont_r   <= cont_nxt_s;
      settle_r <= settle_nxt_s;
      tmo_r    <= tmo_nxt_s;
      req_r    <= req_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      terr_r   <= terr_nxt_s;
    end
  end

  assign bus.addr       = addr_r;
  assign bus.sample_req = req_r;
  assign busy           = busy_r;
  assign sweep_done     = done_r;
  assign timeout_err    = terr_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Randomized self-checking bench for mux_scan_sequencer; skip tests are built
// only when CHAN_SKIP_EN is defined.
module tb_mux_scan_sequencer;

  localparam int ADDR_W      = 6;
  localparam int SETTLE_CYC  = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int CNT_W       = 16;
  localparam int NCH         = 1 << ADDR_W;
  localparam int WAIT_MAX    = 4 * SETTLE_CYC + NCH + 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic              continuous;
  logic [ADDR_W-1:0] first_ch;
  logic [ADDR_W-1:0] last_ch;
  logic              busy;
  logic              sweep_done;
  logic              timeout_err;
`ifdef CHAN_SKIP_EN
  logic [NCH-1:0]    skip_mask;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux_scan_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  mux_scan_sequencer #(
    .ADDR_W      (ADDR_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .first_ch    (first_ch),
    .last_ch     (last_ch),
`ifdef CHAN_SKIP_EN
    .skip_mask   (skip_mask),
`endif
    .busy        (busy),
    .sweep_done  (sweep_done),
    .timeout_err (timeout_err),
    .bus         (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for sample_req; stray acks are thrown in while no request is pending.
  task automatic wait_req(output int waited);
    waited = 0;
    while (!bus.sample_req && waited < WAIT_MAX) begin
      bus.sample_ack = 1'($urandom_range(0, 1));
      tick();
      bus.sample_ack = 1'b0;
      waited++;
      check_val("done_quiet", 32'(sweep_done), 32'd0);
    end
  endtask

  // One programmed scan, checked against the channel list it should visit.
  task automatic run_sweep(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input logic cont, input int nsweeps);
    int chans[$];
    int gaps[$];
    int ch;
    int gap;
    int waited;
    int d;
    logic sk;
    logic last_one;
    ch  = int'(f);
    gap = 0;
    for (int k = 0; k < NCH; k++) begin
      sk = 1'b0;
`ifdef CHAN_SKIP_EN
      sk = skip_mask[ch[ADDR_W-1:0]];
`endif
      if (sk) begin
        gap++;
      end else begin
        chans.push_back(ch);
        gaps.push_back(gap);
        gap = 0;
      end
      if (ch == int'(l)) break;
      ch = (ch + 1) % NCH;
    end

    first_ch = f; last_ch = l; continuous = cont; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_addr", 32'(bus.addr), 32'(f));
    first_ch   = ADDR_W'($urandom);
    last_ch    = ADDR_W'($urandom);
    continuous = 1'($urandom);

    for (int s = 0; s < nsweeps; s++) begin
      for (int i = 0; i < chans.size(); i++) begin
        wait_req(waited);
        check_val("req_latency", 32'(waited), 32'(SETTLE_CYC + 1 + gaps[i]));
        check_val("req_addr", 32'(bus.addr), 32'(chans[i]));
        d = int'($urandom_range(0, 3));
        for (int k = 0; k < d; k++) begin
          start    = 1'($urandom_range(0, 1));
          first_ch = ADDR_W'($urandom);
          tick();
          start = 1'b0;
          check_val("req_hold", 32'(bus.sample_req), 32'd1);
        end
        bus.sample_ack = 1'b1;
        tick();
        bus.sample_ack = 1'b0;
        last_one = (i == chans.size() - 1);
        check_val("req_drop", 32'(bus.sample_req), 32'd0);
        check_val("sweep_done", 32'(sweep_done), 32'(last_one));
        if (last_one && !cont) begin
          check_val("end_busy", 32'(busy), 32'd0);
          check_val("end_addr", 32'(bus.addr), 32'(l));
        end else begin
          check_val("run_busy", 32'(busy), 32'd1);
        end
      end
    end
    if (cont) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_val("cont_stop_busy", 32'(busy), 32'd0);
      check_val("cont_stop_req", 32'(bus.sample_req), 32'd0);
      check_val("cont_stop_done", 32'(sweep_done), 32'd0);
    end
  endtask

  initial begin
    int waited;
    int n_req;
    int n_done;
    logic [ADDR_W-1:0] f;
    logic [ADDR_W-1:0] l;
    logic c;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    first_ch = '0; last_ch = '0; bus.sample_ack = 1'b0;
`ifdef CHAN_SKIP_EN
    skip_mask = '0;
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_val("rst_addr", 32'(bus.addr), 32'd0);
    check_val("rst_req", 32'(bus.sample_req), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(sweep_done), 32'd0);
    check_val("rst_terr", 32'(timeout_err), 32'd0);

    run_sweep(6'd2, 6'd4, 1'b0, 1);
    run_sweep(6'd62, 6'd1, 1'b1, 2);
    run_sweep(6'd5, 6'd5, 1'b0, 1);

    // Ack withheld: request must drop after ACK_TIMEOUT cycles with the error flag set.
    first_ch = 6'd10; last_ch = 6'd12; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(waited);
    check_val("tmo_latency", 32'(waited), 32'(SETTLE_CYC + 1));
    for (int k = 1; k <= ACK_TIMEOUT; k++) begin
      tick();
      if (k < ACK_TIMEOUT) begin
        check_val("tmo_hold", 32'(bus.sample_req), 32'd1);
      end else begin
        check_val("tmo_req", 32'(bus.sample_req), 32'd0);
        check_val("tmo_err", 32'(timeout_err), 32'd1);
        check_val("tmo_busy", 32'(busy), 32'd0);
        check_val("tmo_done", 32'(sweep_done), 32'd0);
      end
    end
    first_ch = 6'd20; last_ch = 6'd20; start = 1'b1;
    tick();
    start = 1'b0;
    check_val("tmo_clear", 32'(timeout_err), 32'd0);
    check_val("tmo_restart_addr", 32'(bus.addr), 32'd20);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // Stop while settling.
    first_ch = 6'd30; last_ch = 6'd33; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("stop_settle_busy", 32'(busy), 32'd0);
    check_val("stop_settle_req", 32'(bus.sample_req), 32'd0);
    check_val("stop_settle_addr", 32'(bus.addr), 32'd30);
    check_val("stop_settle_done", 32'(sweep_done), 32'd0);
    repeat (SETTLE_CYC + 3) tick();
    check_val("stop_settle_quiet", 32'(bus.sample_req), 32'd0);

    // Stop while requesting.
    first_ch = 6'd40; last_ch = 6'd41; start = 1'b1;
    tick();
    start = 1'b0;
    wait_req(waited);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_val("stop_req_busy", 32'(busy), 32'd0);
    check_val("stop_req_req", 32'(bus.sample_req), 32'd0);
    check_val("stop_req_addr", 32'(bus.addr), 32'd40);
    check_val("stop_req_done", 32'(sweep_done), 32'd0);

    // start and stop together from idle: nothing begins.
    first_ch = 6'd50; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_val("ss_busy", 32'(busy), 32'd0);
    check_val("ss_addr", 32'(bus.addr), 32'd40);
    tick();
    check_val("ss_busy2", 32'(busy), 32'd0);

    for (int r = 0; r < 6; r++) begin
      f = ADDR_W'($urandom);
      l = ADDR_W'((int'(f) + int'($urandom_range(0, 5))) % NCH);
      c = 1'($urandom);
      run_sweep(f, l, c, c ? 2 : 1);
    end

`ifdef CHAN_SKIP_EN
    skip_mask = '0;
    skip_mask[7:0] = 8'h0A;
    run_sweep(6'd0, 6'd7, 1'b0, 1);
    skip_mask[7:0] = 8'hFF;
    first_ch = 6'd0; last_ch = 6'd7; continuous = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n_req = 0; n_done = 0; waited = 0;
    while (busy && waited < WAIT_MAX) begin
      tick();
      waited++;
      if (bus.sample_req) n_req++;
      if (sweep_done) n_done++;
    end
    check_val("allskip_req", 32'(n_req), 32'd0);
    check_val("allskip_done", 32'(n_done), 32'd1);
    check_val("allskip_busy", 32'(busy), 32'd0);
    check_val("allskip_addr", 32'(bus.addr), 32'd7);
    skip_mask = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
